// File: rtl/decode_stage_hs_pkg.sv
// rtl/decode_stage_hs_pkg.sv - decode field offsets, control decode and ID/EX bundle types
// Widths here are the CPU configuration; the module parameters default to them.
package decode_pkg;

  localparam int P_DATA_W  = 18;
  localparam int P_INSTR_W = 33;
  localparam int P_REG_AW  = 5;
  localparam int P_PC_W    = 18;
  localparam int P_IMM_W   = 12;
  localparam int P_RGB_W   = 2;

  localparam int INM_BIT = P_INSTR_W - 1;
  localparam int TIPO_LO = P_INSTR_W - 3;
  localparam int OP_LO   = P_INSTR_W - 5;
  localparam int RS1_LO  = OP_LO - P_REG_AW;
  localparam int RS2_LO  = RS1_LO - P_REG_AW;

  typedef enum logic [1:0] {
    IMM_SEXT   = 2'b00,
    IMM_ZEXT   = 2'b01,
    IMM_SEXT_D = 2'b10,
    IMM_ZERO   = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic               reg_write;
    logic               alu_src;
    logic               mem_write;
    logic               result_src;
    logic               branch;
    logic [2:0]         alu_control;
    logic [P_RGB_W-1:0] rgb;
    imm_src_e           imm_src;
  } ctrl_t;

  typedef struct packed {
    logic                reg_write;
    logic                alu_src;
    logic                mem_write;
    logic                result_src;
    logic                branch;
    logic [2:0]          alu_control;
    logic [P_RGB_W-1:0]  rgb;
    logic [P_DATA_W-1:0] rd1;
    logic [P_DATA_W-1:0] rd2;
    logic [P_DATA_W-1:0] imm_ext;
    logic [P_REG_AW-1:0] rs1;
    logic [P_REG_AW-1:0] rs2;
    logic [P_REG_AW-1:0] rd;
    logic [P_PC_W-1:0]   pc;
    logic [P_PC_W-1:0]   pc_plus4;
  } ex_bundle_t;

  // tipo: 00 ALU, 01 load/store (op[0]=1 store), 10 branch, 11 colour op
  function automatic ctrl_t control_unit(input logic inm, input logic [1:0] tipo,
                                         input logic [1:0] op);
    ctrl_t c;
    c = '0;
    c.imm_src = IMM_SEXT;
    unique case (tipo)
      2'b00: begin
        c.reg_write   = 1'b1;
        c.alu_src     = inm;
        c.alu_control = {1'b0, op};
      end
      2'b01: begin
        c.alu_src    = 1'b1;
        c.reg_write  = ~op[0];
        c.result_src = ~op[0];
        c.mem_write  = op[0];
      end
      2'b10: begin
        c.branch      = 1'b1;
        c.alu_control = 3'b001;
        c.imm_src     = IMM_SEXT_D;
      end
      default: begin
        c.reg_write   = 1'b1;
        c.alu_src     = inm;
        c.alu_control = {1'b1, op};
        c.rgb         = P_RGB_W'(op);
        c.imm_src     = inm ? IMM_ZEXT : IMM_ZERO;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_hs_if.sv
// rtl/decode_stage_hs_if.sv - fetch, writeback and ID/EX handshake bundle of the decode stage
interface decode_stage_hs_if #(
  parameter int DATA_W  = decode_pkg::P_DATA_W,
  parameter int INSTR_W = decode_pkg::P_INSTR_W,
  parameter int REG_AW  = decode_pkg::P_REG_AW,
  parameter int PC_W    = decode_pkg::P_PC_W,
  parameter int RGB_W   = decode_pkg::P_RGB_W
);
  logic               FlushE;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] InstrD;
  logic [PC_W-1:0]    PCD;
  logic [PC_W-1:0]    PCPlus4D;
  logic               RegWriteW;
  logic [REG_AW-1:0]  RDW;
  logic [DATA_W-1:0]  ResultW;
  logic               out_valid;
  logic               out_ready;
  logic               RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]         ALUControlE;
  logic [RGB_W-1:0]   RGB_E;
  logic [DATA_W-1:0]  RD1_E, RD2_E, Imm_Ext_E;
  logic [REG_AW-1:0]  RS1_E, RS2_E, RD_E;
  logic [PC_W-1:0]    PCE, PCPlus4E;

  modport slave (
    input  FlushE, in_valid, InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, out_ready,
    output in_ready, out_valid, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
           ALUControlE, RGB_E, RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E
  );

  modport master (
    output FlushE, in_valid, InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, out_ready,
    input  in_ready, out_valid, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
           ALUControlE, RGB_E, RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_stage_hs_regfile_bypass.sv
// rtl/decode_stage_hs_regfile_bypass.sv - 2R1W register file with write-first read bypass
module regfile_bypass #(
  parameter int DATA_W   = 18,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);
  localparam int NREGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;

  assign wr_en = we_i && !((ZERO_REG != 0) && (wa_i == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Same-cycle WB data wins so the ID stage never sees a stale value
  assign rd1_o = ((ZERO_REG != 0) && (ra1_i == '0)) ? '0 :
                 (wr_en && (wa_i == ra1_i))         ? wd_i : regs_q[ra1_i];
  assign rd2_o = ((ZERO_REG != 0) && (ra2_i == '0)) ? '0 :
                 (wr_en && (wa_i == ra2_i))         ? wd_i : regs_q[ra2_i];
endmodule

// File: rtl/decode_stage_hs.sv
// rtl/decode_stage_hs.sv - ID stage with load-use interlock, flush and ID/EX handshake register
module decode_stage_hs
  import decode_pkg::*;
#(
  parameter int DATA_W   = P_DATA_W,
  parameter int INSTR_W  = P_INSTR_W,
  parameter int REG_AW   = P_REG_AW,
  parameter int PC_W     = P_PC_W,
  parameter int IMM_W    = P_IMM_W,
  parameter int RGB_W    = P_RGB_W,
  parameter int ZERO_REG = 1
) (
  input logic              clk,
  input logic              rst,
  decode_stage_hs_if.slave bus
);
  logic [INSTR_W-1:0] instr;
  logic [REG_AW-1:0]  rs1, rs2;
  logic [DATA_W-1:0]  rd1, rd2, imm_ext;
  logic [PC_W-1:0]    pc, pc_plus4;
  logic               uses_rs2, hazard, in_ready, load;
  ctrl_t              ctrl;
  ex_bundle_t         ex_q, ex_d, ex_new;
  logic               valid_q, valid_d;

  assign instr    = bus.InstrD;
  assign pc       = bus.PCD;
  assign pc_plus4 = bus.PCPlus4D;
  assign rs1      = instr[RS1_LO +: REG_AW];
  assign rs2      = instr[RS2_LO +: REG_AW];
  assign uses_rs2 = ~instr[INM_BIT];
  assign ctrl     = control_unit(instr[INM_BIT], instr[TIPO_LO +: 2], instr[OP_LO +: 2]);

  regfile_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we_i  (bus.RegWriteW),
    .wa_i  (bus.RDW),
    .wd_i  (bus.ResultW),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  always_comb begin
    imm_ext = '0;
    unique case (ctrl.imm_src)
      IMM_SEXT:   imm_ext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
      IMM_ZEXT:   imm_ext = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
      IMM_SEXT_D: imm_ext = instr[DATA_W-1:0];
      default:    imm_ext = '0;
    endcase
  end

  // A load in EX cannot forward its data yet; stall the dependent instruction one cycle
  assign hazard = valid_q && ex_q.result_src && ex_q.reg_write &&
                  ((ex_q.rd == rs1) || (uses_rs2 && (ex_q.rd == rs2))) &&
                  !((ZERO_REG != 0) && (ex_q.rd == '0));

  assign in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.FlushE;
  assign load     = bus.in_valid && in_ready;

  always_comb begin
    ex_new             = '0;
    ex_new.reg_write   = ctrl.reg_write;
    ex_new.alu_src     = ctrl.alu_src;
    ex_new.mem_write   = ctrl.mem_write;
    ex_new.result_src  = ctrl.result_src;
    ex_new.branch      = ctrl.branch;
    ex_new.alu_control = ctrl.alu_control;
    ex_new.rgb         = RGB_W'(ctrl.rgb);
    ex_new.rd1         = rd1;
    ex_new.rd2         = rd2;
    ex_new.imm_ext     = imm_ext;
    ex_new.rs1         = rs1;
    ex_new.rs2         = rs2;
    ex_new.rd          = rs1;
    ex_new.pc          = pc;
    ex_new.pc_plus4    = pc_plus4;
  end

  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    if (bus.FlushE) begin
      valid_d        = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.branch    = 1'b0;
    end else if (load) begin
      ex_d    = ex_new;
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
      if (hazard) begin
        ex_d.reg_write = 1'b0;
        ex_d.mem_write = 1'b0;
        ex_d.branch    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.RegWriteE   = ex_q.reg_write;
  assign bus.ALUSrcE     = ex_q.alu_src;
  assign bus.MemWriteE   = ex_q.mem_write;
  assign bus.ResultSrcE  = ex_q.result_src;
  assign bus.BranchE     = ex_q.branch;
  assign bus.ALUControlE = ex_q.alu_control;
  assign bus.RGB_E       = ex_q.rgb;
  assign bus.RD1_E       = ex_q.rd1;
  assign bus.RD2_E       = ex_q.rd2;
  assign bus.Imm_Ext_E   = ex_q.imm_ext;
  assign bus.RS1_E       = ex_q.rs1;
  assign bus.RS2_E       = ex_q.rs2;
  assign bus.RD_E        = ex_q.rd;
  assign bus.PCE         = ex_q.pc;
  assign bus.PCPlus4E    = ex_q.pc_plus4;
endmodule

// File: tb/tb_decode_stage_hs.sv
// tb/tb_decode_stage_hs.sv - directed self-checking bench for decode_stage_hs
module tb_decode_stage_hs;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  decode_stage_hs_if bus ();

  decode_stage_hs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] mk(input logic inm, input logic [1:0] tipo,
                                     input logic [1:0] op, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic [17:0] low);
    return {inm, tipo, op, r1, r2, low};
  endfunction

  task automatic present(input logic [32:0] ins, input logic [17:0] pcv);
    bus.InstrD   = ins;
    bus.PCD      = pcv;
    bus.PCPlus4D = pcv + 18'd4;
    bus.in_valid = 1'b1;
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    rst           = 1'b0;
    bus.FlushE    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.InstrD    = '0;
    bus.PCD       = '0;
    bus.PCPlus4D  = '0;
    bus.RegWriteW = 1'b0;
    bus.RDW       = '0;
    bus.ResultW   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_regwrite", bus.RegWriteE, 0);
    chk("rst_pce", bus.PCE, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst           = 1'b1;
    bus.out_ready = 1'b1;

    bus.RegWriteW = 1'b1; bus.RDW = 5'd3; bus.ResultW = 18'd5;
    tick();
    bus.RDW = 5'd4; bus.ResultW = 18'd7;
    tick();
    bus.RegWriteW = 1'b0;

    // basic register-form read
    present(mk(1'b0, 2'b00, 2'b01, 5'd3, 5'd4, 18'h0), 18'h100);
    #1 chk("t2_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("t2_out_valid", bus.out_valid, 1);
    chk("t2_rd1", bus.RD1_E, 5);
    chk("t2_rd2", bus.RD2_E, 7);
    chk("t2_rs1", bus.RS1_E, 3);
    chk("t2_rd", bus.RD_E, 3);
    chk("t2_rs2", bus.RS2_E, 4);
    chk("t2_regwrite", bus.RegWriteE, 1);
    chk("t2_aluctl", bus.ALUControlE, 1);
    chk("t2_pce", bus.PCE, 18'h100);
    chk("t2_pc4", bus.PCPlus4E, 18'h104);

    // WB->ID bypass in the decode cycle
    present(mk(1'b0, 2'b00, 2'b00, 5'd3, 5'd4, 18'h0), 18'h104);
    bus.RegWriteW = 1'b1; bus.RDW = 5'd4; bus.ResultW = 18'h2AAAA;
    tick();
    bus.RegWriteW = 1'b0;
    chk("t3_rd2_bypass", bus.RD2_E, 18'h2AAAA);
    chk("t3_rd1", bus.RD1_E, 5);

    // back-to-back stream covering every ImmSrc
    present(mk(1'b1, 2'b00, 2'b10, 5'd1, 5'd0, 18'h00F80), 18'h108);
    tick();
    chk("imm_sext", bus.Imm_Ext_E, 18'h3FF80);
    chk("imm_sext_alusrc", bus.ALUSrcE, 1);
    chk("imm_sext_aluctl", bus.ALUControlE, 2);
    present(mk(1'b1, 2'b11, 2'b10, 5'd1, 5'd0, 18'h00F80), 18'h10C);
    tick();
    chk("imm_zext", bus.Imm_Ext_E, 18'h00F80);
    chk("rgb_2", bus.RGB_E, 2);
    chk("rgb_aluctl", bus.ALUControlE, 6);
    present(mk(1'b0, 2'b10, 2'b00, 5'd1, 5'd2, 18'h20001), 18'h110);
    tick();
    chk("imm_sext_d", bus.Imm_Ext_E, 18'h20001);
    chk("br_branch", bus.BranchE, 1);
    chk("br_regwrite", bus.RegWriteE, 0);
    present(mk(1'b0, 2'b11, 2'b01, 5'd1, 5'd2, 18'h3FFFF), 18'h114);
    tick();
    chk("imm_zero", bus.Imm_Ext_E, 0);
    chk("rgb_1", bus.RGB_E, 1);
    present(mk(1'b1, 2'b01, 2'b01, 5'd5, 5'd0, 18'h00010), 18'h118);
    tick();
    bus.in_valid = 1'b0;
    chk("st_memwrite", bus.MemWriteE, 1);
    chk("st_regwrite", bus.RegWriteE, 0);
    chk("st_imm", bus.Imm_Ext_E, 18'h10);
    tick();
    chk("drain_out_valid", bus.out_valid, 0);

    // r0 is hardwired to zero, bypass included
    bus.RegWriteW = 1'b1; bus.RDW = 5'd0; bus.ResultW = 18'h123;
    tick();
    present(mk(1'b0, 2'b00, 2'b00, 5'd0, 5'd3, 18'h0), 18'h200);
    bus.ResultW = 18'h3FFFF;
    tick();
    bus.RegWriteW = 1'b0;
    bus.in_valid  = 1'b0;
    chk("r0_rd1", bus.RD1_E, 0);
    chk("r0_rd2", bus.RD2_E, 5);

    // load to r0 never interlocks
    present(mk(1'b1, 2'b01, 2'b00, 5'd0, 5'd0, 18'h4), 18'h204);
    tick();
    chk("ld0_resultsrc", bus.ResultSrcE, 1);
    present(mk(1'b0, 2'b00, 2'b00, 5'd0, 5'd3, 18'h0), 18'h208);
    #1 chk("ld0_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("ld0_pce", bus.PCE, 18'h208);

    // load-use on rs1: one bubble then issue
    present(mk(1'b1, 2'b01, 2'b00, 5'd6, 5'd0, 18'h4), 18'h20C);
    tick();
    chk("t4_ld_valid", bus.out_valid, 1);
    chk("t4_ld_resultsrc", bus.ResultSrcE, 1);
    chk("t4_ld_rd", bus.RD_E, 6);
    present(mk(1'b0, 2'b00, 2'b00, 5'd6, 5'd2, 18'h0), 18'h210);
    #1 chk("t4_in_ready_stall", bus.in_ready, 0);
    tick();
    chk("t4_bubble_valid", bus.out_valid, 0);
    chk("t4_bubble_regwrite", bus.RegWriteE, 0);
    chk("t4_in_ready_after", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_issue_valid", bus.out_valid, 1);
    chk("t4_issue_pce", bus.PCE, 18'h210);
    chk("t4_issue_rs1", bus.RS1_E, 6);

    // load-use on rs2 only matters for register form
    present(mk(1'b1, 2'b01, 2'b00, 5'd6, 5'd0, 18'h4), 18'h214);
    tick();
    present(mk(1'b0, 2'b00, 2'b00, 5'd2, 5'd6, 18'h0), 18'h218);
    #1 chk("rs2_hazard", bus.in_ready, 0);
    bus.InstrD = mk(1'b1, 2'b00, 2'b00, 5'd2, 5'd6, 18'h0);
    #1 chk("rs2_inm_no_hazard", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("rs2_inm_pce", bus.PCE, 18'h218);
    chk("rs2_inm_alusrc", bus.ALUSrcE, 1);

    // downstream stall holds the bundle
    present(mk(1'b0, 2'b00, 2'b01, 5'd3, 5'd4, 18'h0), 18'h300);
    tick();
    chk("t5_pce_x", bus.PCE, 18'h300);
    bus.out_ready = 1'b0;
    present(mk(1'b0, 2'b00, 2'b10, 5'd4, 5'd3, 18'h0), 18'h304);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_in_ready_stall", bus.in_ready, 0);
      tick();
      chk("t5_hold_valid", bus.out_valid, 1);
      chk("t5_hold_pce", bus.PCE, 18'h300);
      chk("t5_hold_rd1", bus.RD1_E, 5);
      chk("t5_hold_rd2", bus.RD2_E, 18'h2AAAA);
    end
    bus.out_ready = 1'b1;
    #1 chk("t5_in_ready_resume", bus.in_ready, 1);
    tick();
    chk("t5_resume_pce", bus.PCE, 18'h304);
    chk("t5_resume_rd1", bus.RD1_E, 18'h2AAAA);
    chk("t5_resume_aluctl", bus.ALUControlE, 2);

    // flush kills EX entry and blocks acceptance
    bus.FlushE = 1'b1;
    present(mk(1'b0, 2'b10, 2'b00, 5'd1, 5'd2, 18'h0), 18'h308);
    #1 chk("t6_in_ready", bus.in_ready, 0);
    tick();
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_regwrite", bus.RegWriteE, 0);
    chk("t6_memwrite", bus.MemWriteE, 0);
    chk("t6_branch", bus.BranchE, 0);
    chk("t6_pce_hold", bus.PCE, 18'h304);
    bus.FlushE = 1'b0;
    tick();
    chk("t6_accept_pce", bus.PCE, 18'h308);
    chk("t6_accept_branch", bus.BranchE, 1);
    bus.FlushE = 1'b1;
    present(mk(1'b0, 2'b00, 2'b00, 5'd1, 5'd2, 18'h0), 18'h30C);
    tick();
    chk("t6_flush_branch", bus.BranchE, 0);
    chk("t6_flush_pce", bus.PCE, 18'h308);
    bus.FlushE   = 1'b0;
    bus.in_valid = 1'b0;

    // async reset mid-stall
    present(mk(1'b0, 2'b00, 2'b01, 5'd3, 5'd4, 18'h0), 18'h400);
    tick();
    chk("t1_pre_regwrite", bus.RegWriteE, 1);
    bus.out_ready = 1'b0;
    present(mk(1'b0, 2'b00, 2'b00, 5'd4, 5'd3, 18'h0), 18'h404);
    #2 rst = 1'b0;
    #1;
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_regwrite", bus.RegWriteE, 0);
    chk("t1_pce", bus.PCE, 0);
    chk("t1_rd1", bus.RD1_E, 0);
    tick();
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    present(mk(1'b0, 2'b00, 2'b00, 5'd3, 5'd4, 18'h0), 18'h500);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_rf_cleared_rd1", bus.RD1_E, 0);
    chk("t1_rf_cleared_rd2", bus.RD2_E, 0);
    chk("t1_post_valid", bus.out_valid, 1);
    chk("t1_post_pce", bus.PCE, 18'h500);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
